// File: rtl/fp_addsub_seq.sv
// Sequencer for an external FP add/sub unit: one operation in flight, done/timeout
// handling with a RECOVER guard against stale done, and a 2-entry result FIFO.
module fp_addsub_seq #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  output logic        fu_enable,
  output logic [31:0] fu_dataa,
  output logic [31:0] fu_datab,
  input  logic        fu_done,
  input  logic [31:0] fu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_timeout,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

  typedef struct packed {
    logic [31:0] result;
    logic        timeout;
  } entry_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  entry_t        mem [2];
  logic          wptr, rptr;
  logic [1:0]    count;
  logic          accept, push, pop;
  entry_t        push_e;

  assign in_ready = (state == IDLE) && (count < 2'd2);
  assign accept   = in_valid && in_ready;

  // tcnt holds the number of BUSY cycles already completed, so the edge that
  // ends the TIMEOUT_CYCLES-th BUSY cycle sees TIMEOUT_CYCLES-1; done still wins there.
  assign push = (state == BUSY) && (fu_done || (tcnt == CW'(TIMEOUT_CYCLES - 1)));

  always_comb begin
    push_e = '0;
    if (fu_done) push_e = '{result: fu_result, timeout: 1'b0};
    else         push_e = '{result: QNAN,      timeout: 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fu_enable <= 1'b0;
      busy      <= 1'b0;
      fu_dataa  <= '0;
      fu_datab  <= '0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          fu_dataa  <= in_a;
          fu_datab  <= {in_b[31] ^ in_op, in_b[30:0]};
          tcnt      <= '0;
          state     <= BUSY;
          fu_enable <= 1'b1;
          busy      <= 1'b1;
        end
        BUSY: if (push) begin
          state     <= RECOVER;
          fu_enable <= 1'b0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        RECOVER: if (!fu_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          fu_enable <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid                 = (count != 2'd0);
  assign {out_result, out_timeout} = mem[rptr];
  assign pop                       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_e;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum BUSY cycles allowed for fu_done to assert.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair valid.
REQ-005 SHALL have port in_ready, output, 1, sequencer accepts an operand pair.
REQ-006 SHALL have ports in_a and in_b, input, 32 each, IEEE-754 single operands.
REQ-007 SHALL have port in_op, input, 1: 0 = add (a+b), 1 = subtract (a-b).
REQ-008 SHALL have port fu_enable, output, 1, enable to the FP add/sub unit.
REQ-009 SHALL have ports fu_dataa and fu_datab, output, 32 each, operands to the unit.
REQ-010 SHALL have port fu_done, input, 1, unit completion flag.
REQ-011 SHALL have port fu_result, input, 32, unit result.
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-014 SHALL have port out_result, output, 32, head result.
REQ-015 SHALL have port out_timeout, output, 1, head result was produced by timeout.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and RECOVER.
REQ-018 SHALL drive in_ready = (state == IDLE) && (buffer count < 2).
REQ-019 On an in_valid && in_ready edge, SHALL latch fu_dataa = in_a and fu_datab = {in_b[31] ^ in_op, in_b[30:0]}, then enter BUSY.
REQ-020 SHALL hold fu_dataa and fu_datab stable from the accept edge until the next accept.
REQ-021 SHALL drive fu_enable = 1 only in BUSY.
REQ-022 In BUSY, on an edge where fu_done = 1, SHALL push {fu_result, timeout = 0} into the output buffer and enter RECOVER.
REQ-023 SHALL count BUSY cycles with a counter cleared on entry to BUSY.
REQ-024 In BUSY, if the counter reaches TIMEOUT_CYCLES with fu_done never sampled 1, SHALL push {32'h7FC00000, timeout = 1} and enter RECOVER.
REQ-025 If fu_done = 1 on the timeout edge, the done result SHALL win.
REQ-026 SHALL stay in RECOVER (fu_enable = 0) until fu_done is sampled 0, then enter IDLE, so that a stale done is never taken as the next result.
REQ-027 SHALL implement the output buffer as a 2-entry FIFO of 33-bit entries {result, timeout}.
REQ-028 SHALL drive out_valid = (count != 0), with out_result and out_timeout taken from the head entry.
REQ-029 SHALL pop on out_valid && out_ready.
REQ-030 On a simultaneous push and pop, count SHALL stay unchanged and order SHALL be preserved.
REQ-031 A push SHALL never hit a full buffer (guaranteed by REQ-018 and one operation in flight); FIFO pointers SHALL wrap modulo 2.
REQ-032 Minimum latency SHALL be: accept at edge E0; fu_enable high in cycle 1; done sampled at E2; out_valid high in cycle 3.
REQ-033 With a unit that registers done one cycle after enable, in_ready SHALL be high again in cycle 5.
REQ-034 SHALL not accept input while busy; in_valid held with in_ready low SHALL have no effect.

Reset
REQ-035 While reset_n = 0, SHALL force immediately, regardless of clk: state = IDLE, fu_enable = 0, fu_dataa = fu_datab = 0, count = 0, pointers = 0, out_valid = 0, out_result = 0, out_timeout = 0, busy = 0, timeout counter = 0.
REQ-036 Reset asserted mid-BUSY or mid-RECOVER SHALL discard the in-flight operation and all buffered results.
REQ-037 After reset release, the first accept SHALL follow REQ-032 timing, gated on fu_done being sampled 0 (via RECOVER rules if necessary).

Verification
REQ-038 Add: a = 3F800000, b = 40000000, op = 0 -> fu_datab = 40000000; out_result = 40400000, out_timeout = 0; out_valid in cycle 3 after accept.
REQ-039 Subtract: a = 40400000, b = 3F800000, op = 1 -> fu_datab = BF800000, out_result = 40000000.
REQ-040 Backpressure: out_ready = 0, issue two ops -> count = 2 and in_ready stays 0; third op held; one pop -> third op accepted; results emerge in order.
REQ-041 Timeout: fu_done tied 0 -> fu_enable high for 16 cycles, then out_result = 7FC00000, out_timeout = 1, sequencer returns to IDLE.
REQ-042 Reset mid-BUSY: assert reset_n = 0 one cycle after accept -> fu_enable = 0 and out_valid = 0 asynchronously; no result after release.
REQ-043 Stale done: hold fu_done = 1 for 3 extra cycles after completion -> sequencer stays in RECOVER, no duplicate push.
